// File: rtl/text_paste_sched.sv
// text_paste_sched: types a downloaded ASCII text file into the Apple-I
// keyboard port. Download bytes are filtered, buffered in a small FIFO and
// presented one at a time on kbd_strobe/kbd_data. After each character the
// CPU reads it, and then a gap follows. A live PS/2 keypress aborts the paste.
//
// Optional build macro TEXTIN_CASEFOLD_EN: when defined, lowercase a-z is
// folded to uppercase in the filter. When undefined, lowercase passes through.
//
// Handshake: kbd_strobe rises together with a new kbd_data value and holds
// until the CPU reads the PIA data register. That read is a one-cycle
// kbd_ack pulse, which drops kbd_strobe on the next clock edge. kbd_ack while
// kbd_strobe is low has no effect.
//
// dbg_state exposes the sequencer state for observation
// (0 IDLE, 1 LOAD, 2 WAIT, 3 GAP, 4 ABORT).

module text_paste_sched #(
    parameter int FIFO_AW  = 4,
    parameter int CHAR_GAP = 25000,
    parameter int CR_GAP   = 250000
) (
    input  logic       clk25,
    input  logic       rst_n,
    input  logic       ioctl_download,
    input  logic       ioctl_wr,
    input  logic [7:0] ioctl_dout,
    output logic       ioctl_wait,
    input  logic       ps2_valid,
    input  logic [6:0] ps2_char,
    input  logic       kbd_ack,
    output logic       kbd_strobe,
    output logic [7:0] kbd_data,
    output logic       pasting,
    output logic       overflow,
    output logic [2:0] dbg_state
);

    localparam int DEPTH  = 1 << FIFO_AW;
    localparam int MAXGAP = (CR_GAP > CHAR_GAP) ? CR_GAP : CHAR_GAP;
    localparam int GW     = $clog2(MAXGAP) + 1;

    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0]   CNT_HIGH = (FIFO_AW+1)'(DEPTH - 1);
    localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
    localparam logic [GW-1:0]      GAP_CHAR = GW'(CHAR_GAP - 1);
    localparam logic [GW-1:0]      GAP_CR   = GW'(CR_GAP - 1);
    localparam logic [GW-1:0]      GAP_ONE  = GW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WAIT  = 3'd2,
        S_GAP   = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    state_t             state;
    logic [GW-1:0]      gap_cnt;
    logic [6:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [FIFO_AW:0]   count_next;
    logic               prev_cr;
    logic               dl_q;

    logic [6:0] b7;
    logic [6:0] f_char;
    logic       f_keep;
    logic       dl_rise;
    logic       accept;
    logic       full;
    logic       empty;
    logic       rd_en;
    logic       wr_ok;
    logic       flush;
    logic [6:0] fifo_head;
    logic       unused_bit7;

    // Bit 7 of the download byte carries no information for 7-bit ASCII.
    assign unused_bit7 = ioctl_dout[7];

    assign dbg_state = state;
    assign dl_rise   = ioctl_download & ~dl_q;
    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign flush     = (state == S_ABORT);
    assign rd_en     = (state == S_LOAD);
    assign accept    = ioctl_wr & f_keep & ~flush;
    // A full FIFO still takes a write when the head is popped in the same cycle.
    assign wr_ok     = accept & (~full | rd_en);
    assign fifo_head = mem[rd_ptr];

    // Character filter: LF to CR (dropped right after a CR), controls and DEL dropped.
    always_comb begin
        b7     = ioctl_dout[6:0];
        f_char = b7;
        f_keep = 1'b1;
        if (b7 == 7'h0A) begin
            f_char = 7'h0D;
            f_keep = ~prev_cr;
        end else if (b7 != 7'h0D && (b7 < 7'h20 || b7 == 7'h7F)) begin
            f_keep = 1'b0;
        end
`ifdef TEXTIN_CASEFOLD_EN
        if (b7 >= 7'h61 && b7 <= 7'h7A) begin
            f_char = b7 - 7'h20;
        end
`endif
    end

    // Next FIFO occupancy; an abort empties the FIFO outright.
    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({wr_ok, rd_en})
                2'b10:   count_next = count + CNT_ONE;
                2'b01:   count_next = count - CNT_ONE;
                default: count_next = count;
            endcase
        end
    end

    // FIFO storage, no reset needed since pointers define validity.
    always_ff @(posedge clk25) begin
        if (wr_ok) begin
            mem[wr_ptr] <= f_char;
        end
    end

    // FIFO pointers, back-pressure, overflow flag and CRLF tracking.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ioctl_wait <= 1'b0;
            overflow   <= 1'b0;
            prev_cr    <= 1'b0;
            dl_q       <= 1'b0;
        end else begin
            dl_q  <= ioctl_download;
            count <= count_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_ok) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (rd_en) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
            end
            // Raised at depth-1 so the write already in flight still fits.
            ioctl_wait <= (count_next >= CNT_HIGH);
            if (dl_rise) begin
                overflow <= 1'b0;
            end
            if (accept && full && !rd_en) begin
                overflow <= 1'b1;
            end
            if (dl_rise) begin
                prev_cr <= 1'b0;
            end else if (ioctl_wr) begin
                prev_cr <= (b7 == 7'h0D);
            end
        end
    end

    // Paste sequencer with registered keyboard-port outputs.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            gap_cnt    <= '0;
            kbd_strobe <= 1'b0;
            kbd_data   <= 8'h80;
            pasting    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ps2_valid) begin
                        // A newer live key simply replaces an unread one.
                        kbd_data   <= {1'b1, ps2_char};
                        kbd_strobe <= 1'b1;
                    end else if (!empty) begin
                        state   <= S_LOAD;
                        pasting <= 1'b1;
                    end else if (kbd_ack) begin
                        kbd_strobe <= 1'b0;
                    end
                end
                S_LOAD: begin
                    kbd_data   <= {1'b1, fifo_head};
                    kbd_strobe <= 1'b1;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (ps2_valid) begin
                        kbd_strobe <= 1'b0;
                        pasting    <= 1'b0;
                        state      <= S_ABORT;
                    end else if (kbd_ack) begin
                        kbd_strobe <= 1'b0;
                        // A CR gets the long gap so BASIC can process the line.
                        gap_cnt    <= (kbd_data[6:0] == 7'h0D) ? GAP_CR : GAP_CHAR;
                        state      <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (ps2_valid) begin
                        pasting <= 1'b0;
                        state   <= S_ABORT;
                    end else if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GAP_ONE;
                    end else if (!empty) begin
                        state <= S_LOAD;
                    end else if (!ioctl_download) begin
                        pasting <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                S_ABORT: begin
                    // Swallow the rest of the download until the HPS ends it.
                    kbd_strobe <= 1'b0;
                    pasting    <= 1'b0;
                    if (!ioctl_download) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_paste_sched.sv
// Bench for text_paste_sched with short gaps (CHAR_GAP=4, CR_GAP=16).
// Expected characters go into exp_q as stimulus is driven and are popped
// when the DUT raises kbd_strobe.

module tb_text_paste_sched;

    localparam int FIFO_AW  = 4;
    localparam int CHAR_GAP = 4;
    localparam int CR_GAP   = 16;
    localparam int LIMIT    = 300;

    logic       clk25 = 1'b0;
    logic       rst_n = 1'b0;
    logic       ioctl_download = 1'b0;
    logic       ioctl_wr = 1'b0;
    logic [7:0] ioctl_dout = 8'h00;
    logic       ioctl_wait;
    logic       ps2_valid = 1'b0;
    logic [6:0] ps2_char = 7'h00;
    logic       kbd_ack = 1'b0;
    logic       kbd_strobe;
    logic [7:0] kbd_data;
    logic       pasting;
    logic       overflow;
    logic [2:0] dbg_state;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    // clock
    always #5 clk25 = ~clk25;

    text_paste_sched #(
        .FIFO_AW  (FIFO_AW),
        .CHAR_GAP (CHAR_GAP),
        .CR_GAP   (CR_GAP)
    ) dut (
        .clk25          (clk25),
        .rst_n          (rst_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .ps2_valid      (ps2_valid),
        .ps2_char       (ps2_char),
        .kbd_ack        (kbd_ack),
        .kbd_strobe     (kbd_strobe),
        .kbd_data       (kbd_data),
        .pasting        (pasting),
        .overflow       (overflow),
        .dbg_state      (dbg_state)
    );

    // All driver tasks start and end 1 ns after a rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk25);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ps2_valid      = 1'b0;
        kbd_ack        = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic write_byte(input logic [7:0] b);
        ioctl_wr   = 1'b1;
        ioctl_dout = b;
        step(1);
        ioctl_wr = 1'b0;
    endtask

    task automatic ack_char();
        step(1);
        kbd_ack = 1'b1;
        step(1);
        kbd_ack = 1'b0;
    endtask

    task automatic wait_strobe(output int cyc);
        cyc = 0;
        while (kbd_strobe !== 1'b1 && cyc < LIMIT) begin
            step(1);
            cyc++;
        end
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (pasting !== 1'b0 && cyc < LIMIT) begin
            step(1);
            cyc++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL reset_wait: got %b want 0", ioctl_wait); end
        total++; if (kbd_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe: got %b want 0", kbd_strobe); end
        total++; if (kbd_data !== 8'h80) begin bad++; $display("FAIL reset_data: got %h want 80", kbd_data); end
        total++; if (pasting !== 1'b0) begin bad++; $display("FAIL reset_pasting: got %b want 0", pasting); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    endtask

    task automatic test_paste_crlf();
        int cyc;
        int exp_gap;
        exp_q.delete();
        ioctl_download = 1'b1;
        step(1);
        write_byte(8'h41); exp_q.push_back(8'hC1);
        write_byte(8'h0D); exp_q.push_back(8'h8D);
        write_byte(8'h0A);
        write_byte(8'h42); exp_q.push_back(8'hC2);
        ioctl_download = 1'b0;
        exp_gap = 0;
        for (int i = 0; i < 3; i++) begin
            wait_strobe(cyc);
            total++;
            if (kbd_strobe !== 1'b1) begin
                bad++; $display("FAIL crlf_timeout: char %0d got no strobe within %0d cycles", i, LIMIT);
            end else begin
                exp_v = exp_q.pop_front();
                if (kbd_data !== exp_v) begin bad++; $display("FAIL crlf_data: char %0d got %h want %h", i, kbd_data, exp_v); end
                if (i > 0) begin
                    total++;
                    if (cyc + 1 !== exp_gap) begin bad++; $display("FAIL crlf_gap: char %0d got %0d want %0d", i, cyc + 1, exp_gap); end
                end
                exp_gap = (exp_v == 8'h8D) ? CR_GAP + 2 : CHAR_GAP + 2;
            end
            ack_char();
        end
        total++; if (kbd_strobe !== 1'b0) begin bad++; $display("FAIL crlf_strobe_drop: got %b want 0", kbd_strobe); end
        total++; if (pasting !== 1'b1) begin bad++; $display("FAIL crlf_pasting_gap: got %b want 1", pasting); end
        wait_idle(cyc);
        total++; if (cyc !== CHAR_GAP) begin bad++; $display("FAIL crlf_pasting_fall: got %0d want %0d", cyc, CHAR_GAP); end
        total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL crlf_idle: got %0d want 0", dbg_state); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL crlf_leftover: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_burst_overflow();
        int cyc;
        logic exp_wait;
        logic exp_ovf;
        exp_q.delete();
        ioctl_download = 1'b1;
        step(1);
        // The first byte moves to kbd_data on the third write cycle, so the
        // FIFO holds 15 after write 16 and is full after write 17.
        for (int k = 1; k <= 20; k++) begin
            write_byte(8'h40 + 8'(k));
            if (k <= 17) exp_q.push_back(8'hC0 + 8'(k));
            exp_wait = (k >= 16);
            exp_ovf  = (k >= 18);
            total++; if (ioctl_wait !== exp_wait) begin bad++; $display("FAIL burst_wait: write %0d got %b want %b", k, ioctl_wait, exp_wait); end
            total++; if (overflow !== exp_ovf) begin bad++; $display("FAIL burst_overflow: write %0d got %b want %b", k, overflow, exp_ovf); end
        end
        ioctl_download = 1'b0;
        for (int i = 0; i < 17; i++) begin
            wait_strobe(cyc);
            total++;
            if (kbd_strobe !== 1'b1) begin
                bad++; $display("FAIL burst_timeout: char %0d got no strobe", i);
            end else begin
                exp_v = exp_q.pop_front();
                if (kbd_data !== exp_v) begin bad++; $display("FAIL burst_data: char %0d got %h want %h", i, kbd_data, exp_v); end
            end
            ack_char();
        end
        wait_idle(cyc);
        total++; if (pasting !== 1'b0) begin bad++; $display("FAIL burst_idle: pasting got %b want 0", pasting); end
        total++; if (kbd_strobe !== 1'b0) begin bad++; $display("FAIL burst_extra_char: got strobe %b data %h want 0", kbd_strobe, kbd_data); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL burst_sticky: got %b want 1", overflow); end
        total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL burst_wait_drain: got %b want 0", ioctl_wait); end
    endtask

    task automatic test_abort();
        int cyc;
        exp_q.delete();
        ioctl_download = 1'b1;
        step(1);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL abort_ovf_clear: got %b want 0", overflow); end
        write_byte(8'h58); exp_q.push_back(8'hD8);
        write_byte(8'h59);
        write_byte(8'h5A);
        wait_strobe(cyc);
        total++;
        if (kbd_strobe !== 1'b1) begin
            bad++; $display("FAIL abort_first_timeout: got no strobe");
        end else begin
            exp_v = exp_q.pop_front();
            if (kbd_data !== exp_v) begin bad++; $display("FAIL abort_first_data: got %h want %h", kbd_data, exp_v); end
        end
        step(1);
        ps2_valid = 1'b1;
        ps2_char  = 7'h41;
        step(1);
        ps2_valid = 1'b0;
        total++; if (kbd_strobe !== 1'b0) begin bad++; $display("FAIL abort_strobe: got %b want 0", kbd_strobe); end
        total++; if (pasting !== 1'b0) begin bad++; $display("FAIL abort_pasting: got %b want 0", pasting); end
        total++; if (dbg_state !== 3'd4) begin bad++; $display("FAIL abort_state: got %0d want 4", dbg_state); end
        write_byte(8'h5B);
        write_byte(8'h5C);
        step(1);
        total++; if (ioctl_wait !== 1'b0) begin bad++; $display("FAIL abort_wait: got %b want 0", ioctl_wait); end
        total++; if (kbd_data !== 8'hD8) begin bad++; $display("FAIL abort_key_forwarded: got %h want d8", kbd_data); end
        step(10);
        total++; if (kbd_strobe !== 1'b0) begin bad++; $display("FAIL abort_hold_strobe: got %b want 0", kbd_strobe); end
        ioctl_download = 1'b0;
        step(2);
        total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL abort_exit: got %0d want 0", dbg_state); end
        step(10);
        total++; if (kbd_strobe !== 1'b0 || pasting !== 1'b0) begin bad++; $display("FAIL abort_flushed: got strobe %b pasting %b want 0 0", kbd_strobe, pasting); end
        ps2_valid = 1'b1;
        ps2_char  = 7'h42;
        exp_q.push_back(8'hC2);
        step(1);
        ps2_valid = 1'b0;
        total++;
        if (kbd_strobe !== 1'b1) begin
            bad++; $display("FAIL live_strobe: got %b want 1", kbd_strobe);
        end else begin
            exp_v = exp_q.pop_front();
            if (kbd_data !== exp_v) begin bad++; $display("FAIL live_data: got %h want %h", kbd_data, exp_v); end
        end
        ack_char();
        total++; if (kbd_strobe !== 1'b0) begin bad++; $display("FAIL live_ack: got %b want 0", kbd_strobe); end
    endtask

    task automatic test_casefold();
        int cyc;
        exp_q.delete();
        ioctl_download = 1'b1;
        step(1);
        write_byte(8'h61);
        write_byte(8'h62);
`ifdef TEXTIN_CASEFOLD_EN
        exp_q.push_back(8'hC1);
        exp_q.push_back(8'hC2);
`else
        exp_q.push_back(8'hE1);
        exp_q.push_back(8'hE2);
`endif
        ioctl_download = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wait_strobe(cyc);
            total++;
            if (kbd_strobe !== 1'b1) begin
                bad++; $display("FAIL case_timeout: char %0d got no strobe", i);
            end else begin
                exp_v = exp_q.pop_front();
                if (kbd_data !== exp_v) begin bad++; $display("FAIL case_data: char %0d got %h want %h", i, kbd_data, exp_v); end
            end
            ack_char();
        end
        wait_idle(cyc);
        total++; if (pasting !== 1'b0) begin bad++; $display("FAIL case_idle: got %b want 0", pasting); end
    endtask

    task automatic test_filter();
        int cyc;
        exp_q.delete();
        ioctl_download = 1'b1;
        step(1);
        write_byte(8'h07);
        write_byte(8'h7F);
        write_byte(8'h31); exp_q.push_back(8'hB1);
        wait_strobe(cyc);
        total++; if (cyc !== 2) begin bad++; $display("FAIL filter_latency: got %0d want 2", cyc); end
        total++;
        if (kbd_strobe !== 1'b1) begin
            bad++; $display("FAIL filter_timeout: got no strobe");
        end else begin
            exp_v = exp_q.pop_front();
            if (kbd_data !== exp_v) begin bad++; $display("FAIL filter_data: got %h want %h", kbd_data, exp_v); end
        end
        ack_char();
        ioctl_download = 1'b0;
        wait_idle(cyc);
        total++; if (kbd_strobe !== 1'b0 || kbd_data !== 8'hB1) begin bad++; $display("FAIL filter_extra: got strobe %b data %h want 0 b1", kbd_strobe, kbd_data); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        ioctl_download = 1'b1;
        step(1);
        write_byte(8'h41);
        write_byte(8'h42);
        write_byte(8'h43);
        wait_strobe(cyc);
        total++; if (dbg_state !== 3'd2) begin bad++; $display("FAIL rmid_in_wait: got %0d want 2", dbg_state); end
        @(negedge clk25);
        rst_n = 1'b0;
        #1;
        total++; if (kbd_strobe !== 1'b0) begin bad++; $display("FAIL rmid_strobe: got %b want 0", kbd_strobe); end
        total++; if (kbd_data !== 8'h80) begin bad++; $display("FAIL rmid_data: got %h want 80", kbd_data); end
        total++; if (pasting !== 1'b0) begin bad++; $display("FAIL rmid_pasting: got %b want 0", pasting); end
        total++; if (ioctl_wait !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL rmid_flags: got wait %b ovf %b want 0 0", ioctl_wait, overflow); end
        total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL rmid_state: got %0d want 0", dbg_state); end
        step(2);
        ioctl_download = 1'b0;
        rst_n = 1'b1;
        step(10);
        total++; if (kbd_strobe !== 1'b0 || pasting !== 1'b0) begin bad++; $display("FAIL rmid_fifo_empty: got strobe %b pasting %b want 0 0", kbd_strobe, pasting); end
    endtask

    initial begin
        test_reset();
        test_paste_crlf();
        test_burst_overflow();
        test_abort();
        test_casefold();
        test_filter();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/text_paste_sched.md
Name: text_paste_sched

Overview:
- Sequences ASCII text downloaded from the HPS into the Apple-I keyboard port, so a loaded .TXT file is "typed" into the Woz Monitor or BASIC.
- Buffers ioctl bytes in a small FIFO and back-pressures the HPS via ioctl_wait.
- Normalises characters and paces them with a CPU-read handshake plus a post-character gap.
- Arbitrates the keyboard port between the paste stream and the live PS/2 keyboard; any live keypress aborts the paste.

Parameters:
- FIFO_AW, 4: FIFO address width; depth = 2**FIFO_AW entries.
- CHAR_GAP, 25000: clk25 cycles idle after each acked character (1 ms).
- CR_GAP, 250000: clk25 cycles idle after an acked CR (10 ms, line processing time).

Ports:
- clk25, in, 1: system clock, 25 MHz.
- rst_n, in, 1: asynchronous active-low reset.
- ioctl_download, in, 1: text download active (already qualified by index).
- ioctl_wr, in, 1: one-cycle byte write strobe.
- ioctl_dout, in, 8: download byte.
- ioctl_wait, out, 1: back-pressure to HPS.
- ps2_valid, in, 1: one-cycle strobe, decoded live key available.
- ps2_char, in, 7: decoded live key ASCII.
- kbd_ack, in, 1: one-cycle pulse when the CPU reads the PIA KBD data register.
- kbd_strobe, out, 1: character pending (drives the PIA KBDCR bit 7 source).
- kbd_data, out, 8: character, bit 7 always 1.
- pasting, out, 1: paste session active (LED).
- overflow, out, 1: sticky, a byte was dropped on a full FIFO.

Behaviour:
- Reset values: ioctl_wait=0, kbd_strobe=0, kbd_data=8'h80, pasting=0, overflow=0. FIFO is empty and the FSM is in IDLE.
- Filter, applied before the FIFO write. Byte b is masked to 7 bits.
  - 0x0A becomes 0x0D, except when the previous accepted byte was 0x0D; that LF is dropped (CRLF yields a single CR).
  - 0x0D is kept.
  - Other bytes below 0x20 and 0x7F are dropped.
  - With TEXTIN_CASEFOLD_EN, 0x61-0x7A become 0x41-0x5A.
  - The prev-CR flag clears on each ioctl_download rising edge.
- FIFO:
  - A write occurs when ioctl_wr is high and the byte survives the filter.
  - ioctl_wait is registered high while count >= depth-1, so one in-flight write is absorbed.
  - A write while full is dropped and sets overflow, which clears only on reset or the next download rising edge.
  - Simultaneous read and write while full is legal; the write is accepted.
- FSM states:
  - IDLE:
    - FIFO non-empty -> LOAD, pasting=1.
    - ps2_valid -> kbd_data={1,ps2_char}, kbd_strobe=1. A live key overwrites an unacked live key.
  - LOAD: pop FIFO head into kbd_data with bit 7 set, kbd_strobe=1 on the next cycle -> WAIT.
  - WAIT:
    - kbd_ack -> kbd_strobe=0, load gap counter with CR_GAP-1 if the char was 0x0D, else CHAR_GAP-1 -> GAP.
    - ps2_valid -> ABORT.
  - GAP: counter decrements to 0.
    - FIFO non-empty -> LOAD.
    - Else if ioctl_download=1, wait here at 0.
    - Else -> IDLE, pasting=0.
    - ps2_valid -> ABORT.
  - ABORT:
    - Flush FIFO, kbd_strobe=0, pasting=0.
    - Discard all further ioctl_wr with ioctl_wait=0 until ioctl_download falls -> IDLE.
    - The aborting keystroke is not forwarded.
- kbd_ack outside WAIT, or while kbd_strobe=0, is ignored, apart from clearing a live-key strobe in IDLE.
- Latency: first FIFO write to kbd_strobe high is 3 cycles (write, IDLE->LOAD, LOAD->WAIT).
- Async reset mid-paste returns everything to reset values immediately. There is no resumption.

Optional Feature:
- TEXTIN_CASEFOLD_EN defined: lowercase a-z is folded to uppercase in the filter. The Apple-I has no lowercase, so BASIC listings paste cleanly.
- Undefined: bytes 0x61-0x7A pass unchanged, 7-bit.

Test Plan:
- Download "A\r\nB" with CHAR_GAP=4 and CR_GAP=16, ack each strobe 2 cycles after it rises. Required kbd_data sequence: 8'hC1, 8'h8D, 8'hC2. Gaps measured from ack to next strobe are 4+2 and 16+2 cycles. pasting falls after the final gap.
- Burst 20 writes with FIFO_AW=4 and no acks. ioctl_wait must rise once count reaches 15. A write forced while full must set overflow=1.
- Mid-paste, assert ps2_valid with 0x41. Required: FIFO flushed, kbd_strobe=0, remaining ioctl_wr discarded. After ioctl_download falls, a new ps2_valid 0x42 gives kbd_data=8'hC2.
- With macro defined, write "ab" -> kbd_data 8'hC1, 8'hC2. Without it -> 8'hE1, 8'hE2.
- Write bytes 0x07 and 0x7F then 0x31. Only 8'hB1 is presented.
- Assert rst_n=0 while in WAIT. Outputs must return to reset values asynchronously, and the FIFO reads empty after release.
